branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/cotm32_pkg.sv | 23 ++
 rtl/bu.sv | 30 +++
 rtl/branch_ctrl.sv | 108 ++++++++++
 tb/tb_branch_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cotm32_pkg.sv
// Shared types for the cotm32 core: branch-unit ops, XLEN and the branch controller FSM states.
package cotm32_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        BU_NONE,
        BU_EQ,
        BU_NE,
        BU_LT,
        BU_GE,
        BU_LTU,
        BU_GEU,
        BU_ALWAYS
    } bu_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StRedirect,
        StFlush
    } br_ctrl_state_t;

endpackage

// File: rtl/bu.sv
// Branch condition unit: evaluates op on a/b and reports take, gated by be.
module bu
    import cotm32_pkg::*;
(
    input  logic            be_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  bu_op_t          op_i,
    output logic            take_o
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (op_i)
            BU_NONE:   cond = 1'b0;
            BU_EQ:     cond = (a_i == b_i);
            BU_NE:     cond = (a_i != b_i);
            BU_LT:     cond = ($signed(a_i) < $signed(b_i));
            BU_GE:     cond = ($signed(a_i) >= $signed(b_i));
            BU_LTU:    cond = (a_i < b_i);
            BU_GEU:    cond = (a_i >= b_i);
            BU_ALWAYS: cond = 1'b1;
            default:   cond = 1'b0;
        endcase
        take_o = be_i & cond;
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: resolves EX-stage control transfers, redirects fetch on
// mispredict, then squashes IF/ID for FLUSH_CYCLES cycles.
module branch_ctrl
    import cotm32_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_br_valid,
    output logic            o_br_ready,
    input  bu_op_t          i_br_op,
    input  logic            i_jalr,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_pred_taken,
    output logic            o_redir_valid,
    input  logic            i_redir_ready,
    output logic [XLEN-1:0] o_redir_pc,
    output logic            o_flush,
    output logic            o_misalign,
    input  logic            i_kill,
    output logic [31:0]     o_mispred_cnt
);

    br_ctrl_state_t  state_q, state_d;
    logic [2:0]      flush_cnt_q;
    logic [XLEN-1:0] redir_pc_q;
    logic            misalign_q;
    logic [31:0]     mispred_cnt_q;

    logic            accept, take, misalign_hit, mispred;
    logic [XLEN-1:0] jalr_sum, taken_tgt, nt_tgt;

    // A kill in the same cycle blocks acceptance so no stale work survives the trap.
    assign accept = i_br_valid & o_br_ready & ~i_kill;

    bu u_bu (
        .be_i   (accept),
        .a_i    (i_rs1),
        .b_i    (i_rs2),
        .op_i   (i_br_op),
        .take_o (take)
    );

    assign jalr_sum     = i_rs1 + i_imm;
    assign taken_tgt    = i_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (i_pc + i_imm);
    assign nt_tgt       = i_pc + XLEN'(4);
    assign misalign_hit = take & taken_tgt[1];
    assign mispred      = accept & (take != i_pred_taken) & ~misalign_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (mispred) state_d = StRedirect;
            StRedirect: begin
                if (i_kill)             state_d = StIdle;
                else if (i_redir_ready) state_d = StFlush;
            end
            StFlush:    if (i_kill || flush_cnt_q == 3'd1) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        o_br_ready    = (state_q == StIdle);
        o_redir_valid = (state_q == StRedirect);
        o_flush       = (state_q == StFlush);
    end

    assign o_redir_pc    = redir_pc_q;
    assign o_misalign    = misalign_q;
    assign o_mispred_cnt = mispred_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flush_cnt_q <= 3'd0;
        end else if (i_kill) begin
            flush_cnt_q <= 3'd0;
        end else if (state_q == StRedirect && i_redir_ready) begin
            flush_cnt_q <= 3'(FLUSH_CYCLES);
        end else if (state_q == StFlush && flush_cnt_q != 3'd0) begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            redir_pc_q    <= '0;
            misalign_q    <= 1'b0;
            mispred_cnt_q <= '0;
        end else begin
            misalign_q <= misalign_hit;
            if (mispred) begin
                redir_pc_q <= take ? taken_tgt : nt_tgt;
                if (mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: expected outputs are queued at stimulus time and
// compared one cycle later.
module tb_branch_ctrl;
    import cotm32_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_br_valid = 1'b0;
    logic        o_br_ready;
    bu_op_t      i_br_op = BU_NONE;
    logic        i_jalr = 1'b0;
    logic [31:0] i_rs1 = '0, i_rs2 = '0, i_pc = '0, i_imm = '0;
    logic        i_pred_taken = 1'b0;
    logic        o_redir_valid;
    logic        i_redir_ready = 1'b0;
    logic [31:0] o_redir_pc;
    logic        o_flush;
    logic        o_misalign;
    logic        i_kill = 1'b0;
    logic [31:0] o_mispred_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 i_clk = ~i_clk;

    branch_ctrl #(.FLUSH_CYCLES(2)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_br_valid    (i_br_valid),
        .o_br_ready    (o_br_ready),
        .i_br_op       (i_br_op),
        .i_jalr        (i_jalr),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .i_pc          (i_pc),
        .i_imm         (i_imm),
        .i_pred_taken  (i_pred_taken),
        .o_redir_valid (o_redir_valid),
        .i_redir_ready (i_redir_ready),
        .o_redir_pc    (o_redir_pc),
        .o_flush       (o_flush),
        .o_misalign    (o_misalign),
        .i_kill        (i_kill),
        .o_mispred_cnt (o_mispred_cnt)
    );

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h with nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic expect_out(input string tag, input logic rdy, input logic rv,
                              input logic fl, input logic mis, input logic [31:0] pc,
                              input logic [31:0] cnt);
        push({tag, "/br_ready"}, {31'd0, rdy});
        push({tag, "/redir_valid"}, {31'd0, rv});
        push({tag, "/flush"}, {31'd0, fl});
        push({tag, "/misalign"}, {31'd0, mis});
        push({tag, "/redir_pc"}, pc);
        push({tag, "/mispred_cnt"}, cnt);
    endtask

    task automatic observe();
        chk({31'd0, o_br_ready});
        chk({31'd0, o_redir_valid});
        chk({31'd0, o_flush});
        chk({31'd0, o_misalign});
        chk(o_redir_pc);
        chk(o_mispred_cnt);
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
        observe();
    endtask

    task automatic drive(input bu_op_t op, input logic jalr, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc,
                         input logic [31:0] imm, input logic pred);
        i_br_valid   = 1'b1;
        i_br_op      = op;
        i_jalr       = jalr;
        i_rs1        = rs1;
        i_rs2        = rs2;
        i_pc         = pc;
        i_imm        = imm;
        i_pred_taken = pred;
    endtask

    // Handshake the pending redirect, then expect exactly two flush cycles and a return to idle.
    task automatic flush_seq(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
        i_br_valid    = 1'b0;
        i_redir_ready = 1'b1;
        expect_out({tag, "_flush1"}, 1'b0, 1'b0, 1'b1, 1'b0, pc, cnt);
        tick();
        i_redir_ready = 1'b0;
        expect_out({tag, "_flush2"}, 1'b0, 1'b0, 1'b1, 1'b0, pc, cnt);
        tick();
        expect_out({tag, "_done"}, 1'b1, 1'b0, 1'b0, 1'b0, pc, cnt);
        tick();
    endtask

    initial begin
        #1 i_rst_n = 1'b0;
        #1;
        expect_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        observe();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        expect_out("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // EQ taken but predicted not-taken: redirect to pc+imm.
        drive(BU_EQ, 1'b0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        expect_out("eq_accept", 1'b0, 1'b1, 1'b0, 1'b0, 32'h120, 32'd1);
        tick();
        flush_seq("eq", 32'h120, 32'd1);

        // Signed LT correctly predicted, then a back-to-back unsigned GEU mispredict.
        drive(BU_LT, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h180, 32'h10, 1'b1);
        expect_out("lt_correct", 1'b1, 1'b0, 1'b0, 1'b0, 32'h120, 32'd1);
        tick();
        drive(BU_GEU, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b0);
        expect_out("geu_next", 1'b0, 1'b1, 1'b0, 1'b0, 32'h340, 32'd2);
        tick();
        flush_seq("geu", 32'h340, 32'd2);

        // NE not taken but predicted taken: redirect to pc+4, fetch stalls 3 cycles.
        drive(BU_NE, 1'b0, 32'd7, 32'd7, 32'h200, 32'h80, 1'b1);
        expect_out("ne_accept", 1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(BU_EQ, 1'b0, 32'd1, 32'd1, 32'h400 + 32'(i * 16), 32'h8, 1'b0);
            expect_out("ne_hold", 1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'd3);
            tick();
        end
        flush_seq("ne", 32'h204, 32'd3);

        // JALR to 0x1002: misaligned, pulse only.
        drive(BU_ALWAYS, 1'b1, 32'h1001, 32'd0, 32'h500, 32'd1, 1'b0);
        expect_out("jalr_mis", 1'b1, 1'b0, 1'b0, 1'b1, 32'h204, 32'd3);
        tick();
        i_br_valid = 1'b0;
        expect_out("jalr_mis_end", 1'b1, 1'b0, 1'b0, 1'b0, 32'h204, 32'd3);
        tick();

        // JALR 0x2003+2 = 0x2005, bit 0 cleared -> 0x2004.
        drive(BU_ALWAYS, 1'b1, 32'h2003, 32'd0, 32'h600, 32'd2, 1'b0);
        expect_out("jalr_clr", 1'b0, 1'b1, 1'b0, 1'b0, 32'h2004, 32'd4);
        tick();
        i_br_valid    = 1'b0;
        i_kill        = 1'b1;
        i_redir_ready = 1'b1;
        expect_out("kill_redir", 1'b1, 1'b0, 1'b0, 1'b0, 32'h2004, 32'd4);
        tick();
        i_kill        = 1'b0;
        i_redir_ready = 1'b0;
        expect_out("kill_noflush", 1'b1, 1'b0, 1'b0, 1'b0, 32'h2004, 32'd4);
        tick();

        // Mispredict presented together with kill must not be accepted.
        drive(BU_EQ, 1'b0, 32'd3, 32'd3, 32'h700, 32'h10, 1'b0);
        i_kill = 1'b1;
        expect_out("kill_block", 1'b1, 1'b0, 1'b0, 1'b0, 32'h2004, 32'd4);
        tick();
        i_kill     = 1'b0;
        i_br_valid = 1'b0;

        // Saturation: preload near all-ones, then two more mispredicts.
        force dut.mispred_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.mispred_cnt_q;
        drive(BU_NE, 1'b0, 32'd1, 32'd2, 32'h700, 32'h100, 1'b0);
        expect_out("sat_reach", 1'b0, 1'b1, 1'b0, 1'b0, 32'h800, 32'hFFFF_FFFF);
        tick();
        flush_seq("sat1", 32'h800, 32'hFFFF_FFFF);
        drive(BU_LTU, 1'b0, 32'd1, 32'd2, 32'h900, 32'h20, 1'b0);
        expect_out("sat_hold", 1'b0, 1'b1, 1'b0, 1'b0, 32'h920, 32'hFFFF_FFFF);
        tick();
        i_br_valid    = 1'b0;
        i_redir_ready = 1'b1;
        expect_out("sat_flush", 1'b0, 1'b0, 1'b1, 1'b0, 32'h920, 32'hFFFF_FFFF);
        tick();
        i_redir_ready = 1'b0;

        // Asynchronous reset in the middle of FLUSH, between clock edges.
        #2 i_rst_n = 1'b0;
        #1;
        expect_out("async_reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        observe();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        expect_out("no_reissue1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        expect_out("no_reissue2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
